// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a shadow Fibonacci LFSR to an
// incoming serial stream, reports lock, pulses err on mismatches and counts them.
module lfsr_checker #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned ERR_CNT_W   = 16,
  parameter int unsigned LOCK_THRESH = 8,
  parameter int unsigned UNLOCK_ERRS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resync,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic [WIDTH-1:0]     taps,
  input  logic                 clear_errs,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     hist_state
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int unsigned MISS_W  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    FILL,
    VERIFY,
    LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hist_q, hist_d;
  logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [ERR_CNT_W-1:0] cnt_base;
  logic                 pred;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    pred        = ^(taps & hist_q);
    // Clear applies first so an error in the same cycle still lands as 1.
    cnt_base    = clear_errs ? '0 : err_count_q;
    err_count_d = cnt_base;

    if (resync) begin
      state_d     = FILL;
      hist_d      = '0;
      fill_cnt_d  = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        FILL: begin
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
            state_d     = VERIFY;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          // An all-zero history predicts zeros forever; never count it as lock.
          if (hist_q == '0 || in_bit != pred) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MATCH_W'(LOCK_THRESH - 1)) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so one corrupted bit costs one error.
          hist_d = {hist_q[WIDTH-2:0], pred};
          if (in_bit != pred) begin
            err_d       = 1'b1;
            match_cnt_d = '0;
            if (cnt_base != '1) begin
              err_count_d = cnt_base + 1'b1;
            end
            if (miss_cnt_q == MISS_W'(UNLOCK_ERRS - 1)) begin
              state_d    = FILL;
              hist_d     = '0;
              fill_cnt_d = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end else if (match_cnt_q == MATCH_W'(LOCK_THRESH - 1)) begin
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign hist_state = hist_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus tasks push the expected outputs
// for each clock edge; a monitor pops and compares one time unit after the edge.
module tb_lfsr_checker;

  logic       clk;
  logic       rst;
  logic       resync;
  logic       in_valid;
  logic       in_bit;
  logic [4:0] taps;
  logic       clear_errs;
  logic       locked;
  logic       err;
  logic [3:0] err_count;
  logic [4:0] hist_state;

  lfsr_checker #(
    .WIDTH      (5),
    .ERR_CNT_W  (4),
    .LOCK_THRESH(8),
    .UNLOCK_ERRS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .resync    (resync),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .taps      (taps),
    .clear_errs(clear_errs),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .hist_state(hist_state)
  );

  typedef struct {
    logic       lock;
    logic       err;
    logic [3:0] cnt;
    logic [4:0] h;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  bit         chk;
  int         total;
  int         bad;
  logic [4:0] g;
  logic [4:0] mh;
  logic       cur_lock;
  logic [5:0] pat;
  int         ec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    if (chk) begin
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow got=empty want=entry t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check("locked", 32'(locked), 32'(e.lock));
        check("err", 32'(err), 32'(e.err));
        check("err_count", 32'(err_count), 32'(e.cnt));
        check("hist_state", 32'(hist_state), 32'(e.h));
      end
    end
  end

  // One valid beat of the generator stream, optionally corrupted.
  task automatic gen_beat(input bit flip, input bit e_lock, input bit e_err,
                          input logic [3:0] e_cnt, input bit unlock, input bit clr);
    logic b;
    @(negedge clk);
    b          = ^(taps & g);
    g          = {g[3:0], b};
    in_valid   = 1'b1;
    in_bit     = b ^ flip;
    resync     = 1'b0;
    clear_errs = clr;
    mh         = cur_lock ? {mh[3:0], b} : {mh[3:0], b ^ flip};
    if (unlock) mh = '0;
    cur_lock   = e_lock;
    sb.push_back('{e_lock, e_err, e_cnt, mh});
    chk        = 1'b1;
  endtask

  task automatic raw_beat(input logic bitv, input logic [3:0] e_cnt);
    @(negedge clk);
    in_valid   = 1'b1;
    in_bit     = bitv;
    resync     = 1'b0;
    clear_errs = 1'b0;
    mh         = {mh[3:0], bitv};
    sb.push_back('{1'b0, 1'b0, e_cnt, mh});
    chk        = 1'b1;
  endtask

  task automatic idle(input int n, input bit e_lock, input logic [3:0] e_cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      in_bit     = 1'($urandom_range(0, 1));
      resync     = 1'b0;
      clear_errs = 1'b0;
      sb.push_back('{e_lock, 1'b0, e_cnt, mh});
      chk        = 1'b1;
    end
  endtask

  task automatic clear_cycle(input bit e_lock);
    @(negedge clk);
    in_valid   = 1'b0;
    resync     = 1'b0;
    clear_errs = 1'b1;
    sb.push_back('{e_lock, 1'b0, 4'd0, mh});
    chk        = 1'b1;
  endtask

  // Resync with a simultaneous valid beat: the beat must be ignored.
  task automatic resync_cycle(input logic [3:0] e_cnt);
    @(negedge clk);
    in_valid   = 1'b1;
    in_bit     = 1'($urandom_range(0, 1));
    resync     = 1'b1;
    clear_errs = 1'b0;
    mh         = '0;
    cur_lock   = 1'b0;
    sb.push_back('{1'b0, 1'b0, e_cnt, 5'd0});
    chk        = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    resync     = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    taps       = '0;
    clear_errs = 1'b0;
    g          = 5'b00001;
    mh         = '0;
    cur_lock   = 1'b0;
    total      = 0;
    bad        = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst        = 1'b0;
      in_valid   = 1'($urandom_range(0, 1));
      in_bit     = 1'($urandom_range(0, 1));
      resync     = 1'($urandom_range(0, 1));
      clear_errs = 1'($urandom_range(0, 1));
      taps       = 5'($urandom);
      sb.push_back('{1'b0, 1'b0, 4'd0, 5'd0});
      chk        = 1'b1;
    end
    @(negedge clk);
    rst        = 1'b1;
    taps       = 5'b10100;
    in_valid   = 1'b0;
    resync     = 1'b0;
    clear_errs = 1'b0;
    sb.push_back('{1'b0, 1'b0, 4'd0, 5'd0});

    // Clean acquisition: lock after beat 13, then 124 clean locked beats.
    for (int i = 1; i <= 137; i++) gen_beat(1'b0, i >= 13, 1'b0, 4'd0, 1'b0, 1'b0);

    // Single flip, back-to-back beats.
    gen_beat(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) gen_beat(1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    clear_cycle(1'b1);

    // Single flip with 1-3 cycle gaps between beats.
    ec = 0;
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(1, 3), 1'b1, 4'(ec));
      if (i == 3) ec = 1;
      gen_beat(i == 3, 1'b1, i == 3, 4'(ec), 1'b0, 1'b0);
    end
    clear_cycle(1'b1);

    // Burst: four flips in six beats drops lock on the fourth.
    pat = 6'b101011;
    ec  = 0;
    for (int i = 0; i < 6; i++) begin
      if (pat[i]) ec++;
      gen_beat(pat[i], i < 5, pat[i], 4'(ec), i == 5, 1'b0);
    end
    for (int i = 1; i <= 13; i++) gen_beat(1'b0, i == 13, 1'b0, 4'd4, 1'b0, 1'b0);

    // All-zero stream never locks, with real taps and with zero taps.
    resync_cycle(4'd4);
    for (int i = 0; i < 100; i++) raw_beat(1'b0, 4'd4);
    resync_cycle(4'd4);
    taps = 5'b00000;
    for (int i = 0; i < 100; i++) raw_beat(1'b0, 4'd4);

    // Saturation of the 4-bit counter, clear colliding with an error, resync.
    resync_cycle(4'd4);
    taps = 5'b10100;
    clear_cycle(1'b0);
    for (int i = 1; i <= 13; i++) gen_beat(1'b0, i == 13, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      ec = (k < 15) ? k : 15;
      gen_beat(1'b1, 1'b1, 1'b1, 4'(ec), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) gen_beat(1'b0, 1'b1, 1'b0, 4'(ec), 1'b0, 1'b0);
    end
    gen_beat(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
    resync_cycle(4'd1);
    idle(2, 1'b0, 4'd1);

    @(negedge clk);
    chk      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
